muldiv_unit: RTL and testbench

- Iterative multiply/divide unit in the EX stage, alongside the ALU.
- Consumes the same A/B operands the ALU receives.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the results in architectural HI/LO registers.
- The hazard unit stalls on busy. MFHI/MFLO read HI/LO directly. MTHI/MTLO write them.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_if.sv | 32 +++
 rtl/muldiv_signfix.sv | 19 +
 rtl/muldiv_unit.sv | 141 ++++++++++++++
 tb/tb_muldiv_unit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide unit.
//   md_op_e    : MDOperation encodings (MULT, MULTU, DIV, DIVU)
//   md_state_e : sequencer states (IDLE, CALC, FIX)
//   MD_ITER    : iterations per operation on the shift/subtract path
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } md_state_e;

  localparam int unsigned MD_ITER = 32;

  function automatic logic md_is_mul(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: EX-stage request/result bundle between the pipeline and muldiv_unit.
//   MDStart, MDOperation, A, B, MTHI, MTLO : pipeline -> unit
//   Busy, Done, HI, LO                     : unit -> pipeline
// master = pipeline side, slave = muldiv_unit side.
// WIDTH must match the WIDTH of the muldiv_unit it is bound to.
interface muldiv_if #(
  parameter int WIDTH = 32
) ();
  import muldiv_pkg::*;

  logic             MDStart;
  logic [1:0]       MDOperation;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             MTHI;
  logic             MTLO;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output MDStart, MDOperation, A, B, MTHI, MTLO,
    input  Busy, Done, HI, LO
  );

  modport slave (
    input  MDStart, MDOperation, A, B, MTHI, MTLO,
    output Busy, Done, HI, LO
  );

endinterface

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: combinational conditional two's-complement negate.
//   neg  : 1 -> dout = -din, 0 -> dout = din
//   din  : N-bit value
//   dout : N-bit result
// Used for operand magnitude at capture and for sign correction of results.
module muldiv_signfix #(
  parameter int N = 32
) (
  input  logic         neg,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);

  always_comb begin
    dout = din;
    if (neg) dout = ~din + 1'b1;
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : muldiv_if.slave (MDStart, MDOperation, A, B, MTHI, MTLO in;
//           Busy, Done, HI, LO out)
// Operations take 33 cycles: 32 shift-add / restoring-divide steps on
// operand magnitudes, then a FIX cycle that applies signs and writes HI/LO.
// Divide by zero yields LO = all ones, HI = original dividend.
// Optional: define MULDIV_FAST_MULT_EN for a single-cycle multiply
// (IDLE -> FIX); divide is unaffected.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  md_state_e          state;
  md_op_e             op_q;
  md_op_e             op_in;
  logic               sa, sb;
  logic               in_sa, in_sb;
  logic               busy_q, done_q;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   opa, opb;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   absa, absb;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_src, prod_fix;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;

  assign op_in = md_op_e'(bus.MDOperation);
  assign in_sa = md_is_signed(op_in) & bus.A[WIDTH-1];
  assign in_sb = md_is_signed(op_in) & bus.B[WIDTH-1];

  muldiv_signfix #(.N(WIDTH)) u_absa (.neg(in_sa), .din(bus.A), .dout(absa));
  muldiv_signfix #(.N(WIDTH)) u_absb (.neg(in_sb), .din(bus.B), .dout(absb));

  // Working pair {hi_r,lo_r}: multiply = {partial product, multiplier},
  // divide = {partial remainder, dividend shifting into quotient}.
  always_comb begin
    mul_sum   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opa} : '0);
    div_shift = {hi_r, lo_r[WIDTH-1]};
    // Partial remainder stays below the divisor, so bit WIDTH of the
    // difference is a clean borrow flag (never set when divisor is zero).
    div_diff  = div_shift - {1'b0, opb};
  end

  always_comb begin
`ifdef MULDIV_FAST_MULT_EN
    prod_src = {{WIDTH{1'b0}}, opa} * {{WIDTH{1'b0}}, opb};
`else
    prod_src = {hi_r, lo_r};
`endif
  end

  muldiv_signfix #(.N(2*WIDTH)) u_prodfix (.neg(sa ^ sb), .din(prod_src), .dout(prod_fix));
  muldiv_signfix #(.N(WIDTH))   u_quofix  (.neg(sa ^ sb), .din(lo_r),     .dout(quo_fix));
  muldiv_signfix #(.N(WIDTH))   u_remfix  (.neg(sa),      .din(hi_r),     .dout(rem_fix));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      op_q   <= MD_MULT;
      sa     <= 1'b0;
      sb     <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.MDStart) begin
            op_q   <= op_in;
            sa     <= in_sa;
            sb     <= in_sb;
            opa    <= absa;
            opb    <= absb;
            hi_r   <= '0;
            lo_r   <= md_is_mul(op_in) ? absb : absa;
            cnt    <= '0;
            busy_q <= 1'b1;
`ifdef MULDIV_FAST_MULT_EN
            state  <= md_is_mul(op_in) ? S_FIX : S_CALC;
`else
            state  <= S_CALC;
`endif
          end else begin
            if (bus.MTHI) hi_q <= bus.A;
            if (bus.MTLO) lo_q <= bus.A;
          end
        end
        S_CALC: begin
          if (md_is_mul(op_q)) begin
            {hi_r, lo_r} <= {mul_sum, lo_r[WIDTH-1:1]};
          end else if (!div_diff[WIDTH]) begin
            hi_r <= div_diff[WIDTH-1:0];
            lo_r <= {lo_r[WIDTH-2:0], 1'b1};
          end else begin
            hi_r <= div_shift[WIDTH-1:0];
            lo_r <= {lo_r[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
        end
        S_FIX: begin
          if (md_is_mul(op_q)) begin
            {hi_q, lo_q} <= prod_fix;
          end else begin
            // Zero divisor leaves the dividend magnitude as remainder, so the
            // signed remainder fix restores the original A in HI.
            lo_q <= (opb == '0) ? '1 : quo_fix;
            hi_q <= rem_fix;
          end
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus ();
  muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));

  int nvec = 0;
  int nfail = 0;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int lat_for(input logic [1:0] op);
    return op[1] ? DIV_LAT : MUL_LAT;
  endfunction

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero and
  // the remainder takes the dividend's sign, matching the architecture.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa_, sb_, q, r, p;
    longint unsigned ua, ub, up;
    sa_ = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    hi = '0;
    lo = '0;
    case (op)
      2'd0: begin p = sa_ * sb_; {hi, lo} = p; end
      2'd1: begin up = ua * ub; {hi, lo} = up; end
      default: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else if (op == 2'd2) begin
          q = sa_ / sb_; r = sa_ % sb_;
          lo = q[31:0]; hi = r[31:0];
        end else begin
          up = ua / ub; lo = up[31:0];
          up = ua % ub; hi = up[31:0];
        end
      end
    endcase
  endfunction

  task automatic wait_done(output int bcyc, output bit to);
    bcyc = 0;
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bus.Done) begin to = 1'b0; break; end
      if (bus.Busy) bcyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output int bcyc, output logic done_after);
    bit to;
    @(negedge clk);
    bus.MDOperation = op; bus.A = a; bus.B = b; bus.MDStart = 1'b1;
    @(negedge clk);
    bus.MDStart = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
    wait_done(bcyc, to);
    if (to) $display("FAIL done_timeout: got no Done expected Done within 100 cycles");
    hi = bus.HI;
    lo = bus.LO;
    @(negedge clk);
    done_after = bus.Done;
  endtask

  initial begin
    logic [31:0] hi, lo, h0, l0, ehi, elo;
    logic [1:0]  op;
    logic [31:0] ra, rb;
    logic        dafter;
    int          bcyc, b2, dcount;
    bit          to;

    tbl[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[1] = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[2] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{2'd3, 32'd100,       32'd7,         32'd2,         32'd14};
    tbl[4] = '{2'd3, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    tbl[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[6] = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    tbl[7] = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    tbl[8] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    tbl[9] = '{2'd1, 32'd6,         32'd7,         32'd0,         32'd42};

    bus.MDStart = 1'b0; bus.MDOperation = 2'd0; bus.A = '0; bus.B = '0;
    bus.MTHI = 1'b0; bus.MTLO = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_hi", bus.HI, 0);
    chk("rst_lo", bus.LO, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_done", bus.Done, 0);
    reset = 1'b1;
    @(negedge clk);

    // MTHI / MTLO in IDLE
    bus.A = 32'hAAAA_5555; bus.MTHI = 1'b1;
    @(negedge clk);
    bus.MTHI = 1'b0;
    chk("mthi", bus.HI, 32'hAAAA_5555);
    bus.A = 32'h0F0F_1234; bus.MTLO = 1'b1;
    @(negedge clk);
    bus.MTLO = 1'b0;
    chk("mtlo", bus.LO, 32'h0F0F_1234);

    // MTHI/MTLO coinciding with MDStart: start wins
    h0 = bus.HI; l0 = bus.LO;
    bus.MDOperation = 2'd3; bus.A = 32'd100; bus.B = 32'd7;
    bus.MDStart = 1'b1; bus.MTHI = 1'b1; bus.MTLO = 1'b1;
    @(negedge clk);
    bus.MDStart = 1'b0; bus.MTHI = 1'b0; bus.MTLO = 1'b0;
    chk("start_wins_hi", bus.HI, h0);
    chk("start_wins_lo", bus.LO, l0);
    wait_done(bcyc, to);
    chk("start_wins_res_hi", bus.HI, 32'd2);
    chk("start_wins_res_lo", bus.LO, 32'd14);
    chk("start_wins_lat", bcyc, DIV_LAT);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, hi, lo, bcyc, dafter);
      chk($sformatf("tbl%0d_hi", i), hi, tbl[i].hi);
      chk($sformatf("tbl%0d_lo", i), lo, tbl[i].lo);
      chk($sformatf("tbl%0d_busy_cycles", i), bcyc, lat_for(tbl[i].op));
      chk($sformatf("tbl%0d_done_width", i), dafter, 0);
    end

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      model(op, ra, rb, ehi, elo);
      run_op(op, ra, rb, hi, lo, bcyc, dafter);
      chk($sformatf("rnd%0d_op%0d_hi", i, op), hi, ehi);
      chk($sformatf("rnd%0d_op%0d_lo", i, op), lo, elo);
      chk($sformatf("rnd%0d_busy_cycles", i), bcyc, lat_for(op));
    end

    // MTHI/MTLO and MDStart pulsed while Busy are ignored
    @(negedge clk);
    bus.A = 32'h1357_2468; bus.MTHI = 1'b1; bus.MTLO = 1'b1;
    @(negedge clk);
    bus.MTHI = 1'b0; bus.MTLO = 1'b0;
    h0 = bus.HI; l0 = bus.LO;
    bus.MDOperation = 2'd3; bus.A = 32'd100; bus.B = 32'd7; bus.MDStart = 1'b1;
    @(negedge clk);
    bus.MDStart = 1'b0;
    bcyc = 0;
    repeat (5) begin
      if (bus.Busy) bcyc++;
      @(negedge clk);
    end
    if (bus.Busy) bcyc++;
    bus.MDOperation = 2'd1; bus.A = 32'h5A5A_5A5A; bus.B = 32'd3;
    bus.MDStart = 1'b1; bus.MTHI = 1'b1; bus.MTLO = 1'b1;
    @(negedge clk);
    bus.MDStart = 1'b0; bus.MTHI = 1'b0; bus.MTLO = 1'b0;
    chk("busy_mthi_ignored", bus.HI, h0);
    chk("busy_mtlo_ignored", bus.LO, l0);
    wait_done(b2, to);
    chk("busy_res_hi", bus.HI, 32'd2);
    chk("busy_res_lo", bus.LO, 32'd14);
    chk("busy_total_cycles", bcyc + b2, DIV_LAT);

    // Asynchronous reset mid-divide
    @(negedge clk);
    bus.MDOperation = 2'd2; bus.A = 32'hFFFF_FFF9; bus.B = 32'd2; bus.MDStart = 1'b1;
    @(negedge clk);
    bus.MDStart = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_before_reset", bus.Busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_hi", bus.HI, 0);
    chk("midrst_lo", bus.LO, 0);
    chk("midrst_busy", bus.Busy, 0);
    chk("midrst_done", bus.Done, 0);
    @(negedge clk);
    reset = 1'b1;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.Done) dcount++;
    end
    chk("no_done_after_reset", dcount, 0);
    run_op(2'd1, 32'd6, 32'd7, hi, lo, bcyc, dafter);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd42);
    chk("post_rst_busy_cycles", bcyc, MUL_LAT);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
